// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, state encoding and key type
package aes_pkg;
  localparam int KEY_W = 128;
  typedef logic [0:KEY_W-1] key_t;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16};
endpackage

// File: rtl/key_expand_seq_if.sv
// key_expand_seq_if: key load / status / read-port bundle (stream taps under KEY_EXPAND_STREAM_EN)
interface key_expand_seq_if;
  import aes_pkg::*;
  logic key_valid;
  key_t key;
  logic key_ready;
  logic busy;
  logic keys_valid;
  logic [0:3] rd_idx;
  key_t rd_key;
`ifdef KEY_EXPAND_STREAM_EN
  logic rk_stream_valid;
  logic [0:3] rk_stream_idx;
  key_t rk_stream_key;
`endif
  modport master (
    output key_valid, key, rd_idx,
`ifdef KEY_EXPAND_STREAM_EN
    input rk_stream_valid, rk_stream_idx, rk_stream_key,
`endif
    input key_ready, busy, keys_valid, rd_key
  );
  modport slave (
    input key_valid, key, rd_idx,
`ifdef KEY_EXPAND_STREAM_EN
    output rk_stream_valid, rk_stream_idx, rk_stream_key,
`endif
    output key_ready, busy, keys_valid, rd_key
  );
endinterface

// File: rtl/key_round_step.sv
// key_round_step: one AES-128 key-schedule round, previous round key -> next round key
module key_round_step
  import aes_pkg::*;
(
  input  key_t       prev_i,
  input  logic [3:0] rnd_i,
  output key_t       next_o
);
  logic [0:31] rot, sub, t, n0, n1, n2, n3;
  assign rot = {prev_i[104:127], prev_i[96:103]};
  for (genvar i = 0; i < 4; i++) begin : g_sb
    assign sub[i*8 +: 8] = SBOX[rot[i*8 +: 8]];
  end
  assign t = sub ^ {RCON[rnd_i], 24'h0};
  assign n0 = prev_i[0:31] ^ t;
  assign n1 = prev_i[32:63] ^ n0;
  assign n2 = prev_i[64:95] ^ n1;
  assign n3 = prev_i[96:127] ^ n2;
  assign next_o = {n0, n1, n2, n3};
endmodule

// File: rtl/key_expand_seq.sv
// key_expand_seq: sequential AES-128 key expansion into a readable round-key table (KEY_EXPAND_STREAM_EN adds a per-round stream tap)
module key_expand_seq
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input logic clk,
  input logic rst,
  key_expand_seq_if.slave bus
);
  state_t     state_q;
  logic [3:0] r_q;
  key_t       last_q, nxt_d, rd_key_q;
  key_t       tbl_q [0:NR];
  logic       key_ready_q, busy_q, keys_valid_q;
  logic       acc;
  assign acc = key_ready_q && bus.key_valid;
  key_round_step u_step (.prev_i(last_q), .rnd_i(r_q), .next_o(nxt_d));
  // FSM: accept key as round 0, then one round key per EXPAND cycle; registered status and read port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q <= '0;
      key_ready_q <= 1'b1;
      busy_q <= 1'b0;
      keys_valid_q <= 1'b0;
      rd_key_q <= '0;
    end else begin
      rd_key_q <= (keys_valid_q && bus.rd_idx <= 4'(NR)) ? tbl_q[bus.rd_idx] : '0;
      if (acc) begin
        tbl_q[0] <= bus.key;
        last_q <= bus.key;
        r_q <= 4'd1;
        state_q <= EXPAND;
        key_ready_q <= 1'b0;
        busy_q <= 1'b1;
        keys_valid_q <= 1'b0;
      end else if (state_q == EXPAND) begin
        tbl_q[r_q] <= nxt_d;
        last_q <= nxt_d;
        r_q <= r_q + 4'd1;
        if (r_q == 4'(NR)) begin
          state_q <= DONE;
          busy_q <= 1'b0;
          keys_valid_q <= 1'b1;
          key_ready_q <= 1'b1;
        end
      end
    end
  end
  assign bus.key_ready = key_ready_q;
  assign bus.busy = busy_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.rd_key = rd_key_q;
`ifdef KEY_EXPAND_STREAM_EN
  logic       sv_q;
  logic [3:0] si_q;
  key_t       sk_q;
  // Stream tap: mirror each table write (key 0 on accept, key r in EXPAND) for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sv_q <= 1'b0;
      si_q <= '0;
      sk_q <= '0;
    end else begin
      sv_q <= acc || state_q == EXPAND;
      si_q <= acc ? 4'd0 : r_q;
      sk_q <= acc ? bus.key : nxt_d;
    end
  end
  assign bus.rk_stream_valid = sv_q;
  assign bus.rk_stream_idx = si_q;
  assign bus.rk_stream_key = sk_q;
`endif
endmodule

// File: tb/tb_key_expand_seq.sv
// tb_key_expand_seq: directed + random checks of key_expand_seq against a word-wise FIPS-197 model
module tb_key_expand_seq;
  parameter int NR = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  key_expand_seq_if bus();
  key_expand_seq #(.NR(NR)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [7:0] sbm [256];
  logic [127:0] mk [0:10];
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbm[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbm[w[31:24]], sbm[w[23:16]], sbm[w[15:8]], sbm[w[7:0]]};
  endfunction
  task automatic model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4 * NR + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic run_key(input logic [127:0] k, input int pulse_at);
    int n;
    model(k);
    bus.key = k;
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    n = 1;
    chk("busy_after_accept", bus.busy, 1);
    chk("kv_low_after_accept", bus.keys_valid, 0);
`ifdef KEY_EXPAND_STREAM_EN
    chk("stream_v0", bus.rk_stream_valid, 1);
    chk("stream_i0", bus.rk_stream_idx, 0);
    chk("stream_k0", bus.rk_stream_key, mk[0]);
`endif
    while (!bus.keys_valid && n < 40) begin
      chk("ready_low_expand", bus.key_ready, 0);
      bus.key_valid = (n == pulse_at);
      if (n == pulse_at) bus.key = rnd128();
      tick;
      n++;
      bus.key_valid = 1'b0;
`ifdef KEY_EXPAND_STREAM_EN
      chk("stream_v", bus.rk_stream_valid, 1);
      chk("stream_i", bus.rk_stream_idx, 128'(n - 1));
      chk("stream_k", bus.rk_stream_key, mk[(n - 1) % 11]);
`endif
    end
    chk("latency", 128'(n), 128'(NR + 1));
    chk("ready_done", bus.key_ready, 1);
    chk("busy_done", bus.busy, 0);
  endtask
  task automatic read_chk(input int idx, input logic [127:0] exp, input string tag);
    bus.rd_idx = 4'(idx);
    tick;
    chk(tag, bus.rd_key, exp);
  endtask
  initial begin
    logic [127:0] k;
    bus.key_valid = 1'b0;
    bus.key = '0;
    bus.rd_idx = '0;
    build_sbox;
    tick;
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    chk("rst_ready", bus.key_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_kv", bus.keys_valid, 0);
    chk("rst_rdkey", bus.rd_key, 0);
    rst = 1'b0;
    read_chk(0, 0, "rd_idle");
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_key(k, 0);
`ifdef KEY_EXPAND_STREAM_EN
    tick;
    chk("stream_v_off", bus.rk_stream_valid, 0);
`endif
    read_chk(0, k, "a1_rk0");
    read_chk(1, 128'ha0fafe1788542cb123a339392a6c7605, "a1_rk1");
    read_chk(10, (NR >= 10) ? 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 : 128'h0, "a1_rk10");
    read_chk(NR, mk[NR], "a1_rkNR");
    for (int i = 11; i < 16; i++) read_chk(i, 0, "rd_oob");
    run_key(0, 0);
    read_chk(1, 128'h62636363626363636263636362636363, "zero_rk1");
    read_chk(10, (NR >= 10) ? 128'hb4ef5bcb3e92e21123e951cf6f8f188e : 128'h0, "zero_rk10");
    for (int t = 0; t < 3; t++) begin
      run_key(rnd128(), 0);
      for (int i = 0; i <= NR; i++) read_chk(i, mk[i], "rand_rk");
    end
    run_key(rnd128(), (NR > 1) ? 2 : 1);
    for (int i = 0; i <= NR; i++) read_chk(i, mk[i], "pulse_rk");
    bus.key = rnd128();
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    chk("abort_kv_low", bus.keys_valid, 0);
    repeat ((NR > 4) ? 4 : NR - 1) tick;
    chk("abort_busy_pre", bus.busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_ready", bus.key_ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_kv", bus.keys_valid, 0);
    chk("abort_rdkey", bus.rd_key, 0);
    read_chk(0, 0, "abort_rd0");
    read_chk(NR, 0, "abort_rdNR");
    run_key(rnd128(), 0);
    for (int i = 0; i <= NR; i++) read_chk(i, mk[i], "reissue_rk");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
